// File: rtl/pc_sequencer.sv
// Fetch-stage PC/EPC owner: picks the next PC among sequential fetch, branch/jump
// redirects, SIIC exception entry and RTI return, and handles stall, flush and halt.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] EPC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jump_reg,
  input  logic        disp_sel,
  input  logic        siic,
  input  logic        rti,
  input  logic        halt,
  input  logic [15:0] target_in,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        ses_sel,
  output logic        jump,
  output logic        get02,
  output logic        get_epc,
  output logic [15:0] epc,
  output logic        flush,
  output logic        in_handler,
  output logic        halted,
  output logic [1:0]  dbg_state   // 0 = RUN, 1 = EXC, 2 = HALT
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXC  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_epc;
  logic        r_flush;
  logic        r_in_handler;
  logic        r_halted;

  // Requests are level signals held by the requester across stall; they are only
  // acted on in RUN with stall low, and only the highest-priority one wins.
  logic w_go;
  logic w_do_halt;
  logic w_do_exc;
  logic w_dbl_fault;
  logic w_do_rti;
  logic w_do_br;

  assign w_go        = rst_n && (r_state == ST_RUN) && !stall;
  assign w_do_halt   = w_go && halt;
  assign w_do_exc    = w_go && !halt && siic && !r_in_handler;
  assign w_dbl_fault = w_go && !halt && siic && r_in_handler;
  assign w_do_rti    = w_go && !halt && !siic && rti;
  assign w_do_br     = w_go && !halt && !siic && !rti && br_taken;

  assign pc_plus2   = r_pc + 16'd2;
  assign get02      = w_do_exc;
  assign get_epc    = w_do_rti;
  assign jump       = w_do_br && jump_reg;
  assign ses_sel    = w_do_br && disp_sel;

  assign pc         = r_pc;
  assign epc        = r_epc;
  assign flush      = r_flush;
  assign in_handler = r_in_handler;
  assign halted     = r_halted;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_epc        <= EPC_RESET;
      r_flush      <= 1'b0;
      r_in_handler <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_do_halt || w_dbl_fault) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_do_exc) begin
            r_epc        <= pc_plus2;
            r_pc         <= target_in;
            r_in_handler <= 1'b1;
            r_flush      <= 1'b1;
            r_state      <= ST_EXC;
          end else if (w_do_rti) begin
            r_pc         <= target_in;
            r_in_handler <= 1'b0;
            r_flush      <= 1'b1;
          end else if (w_do_br) begin
            r_pc    <= target_in;
            r_flush <= 1'b1;
          end else if (w_go) begin
            r_pc <= pc_plus2;
          end
        end
        // The bubble slot: flush was raised on entry, everything else waits.
        ST_EXC:  r_state <= ST_RUN;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a reference model predicts every cycle's
// outputs into a queue, and a monitor pops and compares each cycle.
module tb_pc_sequencer;

  localparam int W = 57;
  localparam logic [1:0] M_RUN  = 2'd0;
  localparam logic [1:0] M_EXC  = 2'd1;
  localparam logic [1:0] M_HALT = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jump_reg = 1'b0, disp_sel = 1'b0;
  logic        siic = 1'b0, rti = 1'b0, halt = 1'b0;
  logic [15:0] target_in = 16'h0000;
  logic [15:0] pc, pc_plus2, epc;
  logic        ses_sel, jump, get02, get_epc, flush, in_handler, halted;
  logic [1:0]  dbg_state;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .jump_reg(jump_reg), .disp_sel(disp_sel), .siic(siic), .rti(rti),
    .halt(halt), .target_in(target_in), .pc(pc), .pc_plus2(pc_plus2),
    .ses_sel(ses_sel), .jump(jump), .get02(get02), .get_epc(get_epc),
    .epc(epc), .flush(flush), .in_handler(in_handler), .halted(halted),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_pc, m_epc;
  logic [1:0]  m_mode;
  bit          m_ih, m_flush, m_halted;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, predict outputs, advance model.
  task automatic step(input bit s, input bit h, input bit si, input bit r, input bit b,
                      input bit jr, input bit ds, input logic [15:0] tgt);
    int ev;
    bit e_ses, e_jump, e_g02, e_gepc;
    logic [15:0] pp;
    ev = 0;
    if (m_mode == M_RUN && !s) begin
      if (h)       ev = 1;
      else if (si) ev = m_ih ? 3 : 2;
      else if (r)  ev = 4;
      else if (b)  ev = 5;
      else         ev = 6;
    end
    e_g02  = (ev == 2);
    e_gepc = (ev == 4);
    e_jump = (ev == 5) && jr;
    e_ses  = (ev == 5) && ds;
    pp = m_pc + 16'd2;
    stall = s; halt = h; siic = si; rti = r; br_taken = b; jump_reg = jr; disp_sel = ds;
    target_in = e_g02 ? 16'h0002 : (e_gepc ? m_epc : tgt);
    exp_q.push_back({m_pc, m_epc, pp, m_flush, m_ih, m_halted,
                     e_ses, e_jump, e_g02, e_gepc, m_mode});
    m_flush = (ev == 2) || (ev == 4) || (ev == 5);
    case (ev)
      1, 3: begin m_mode = M_HALT; m_halted = 1'b1; end
      2: begin m_epc = pp; m_pc = target_in; m_ih = 1'b1; m_mode = M_EXC; end
      4: begin m_pc = target_in; m_ih = 1'b0; end
      5: m_pc = target_in;
      6: m_pc = pp;
      default: if (m_mode == M_EXC) m_mode = M_RUN;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic branch(input logic [15:0] t);
    step(0, 0, 0, 0, 1, 0, 0, t);
  endtask

  // Called at a falling edge: async assert mid-cycle, check before any clock edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 16'h0000);
    check("rst_epc", epc, 16'h0000);
    check("rst_flags", {flush, in_handler, halted, ses_sel, jump, get02, get_epc, dbg_state},
          {7'b0, M_RUN});
    m_pc = 16'h0000; m_epc = 16'h0000; m_mode = M_RUN;
    m_ih = 1'b0; m_flush = 1'b0; m_halted = 1'b0;
    stall = 0; halt = 0; siic = 0; rti = 0; br_taken = 0; jump_reg = 0; disp_sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc, epc, pc_plus2, flush, in_handler, halted, ses_sel, jump, get02, get_epc, dbg_state};
        check("pc", a[56:41], e[56:41]);
        check("epc", a[40:25], e[40:25]);
        check("pc_plus2/flags/ctrl", a[24:0], e[24:0]);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin : driver
    logic [15:0] tgt;
    @(negedge clk);
    do_reset();
    idle(4);                                   // pc 0,2,4,6
    branch(16'h0010);
    step(1, 0, 0, 0, 1, 1, 0, 16'h0300);       // stalled redirect: jump stays 0
    step(1, 0, 0, 0, 1, 1, 0, 16'h0300);
    idle(1);
    branch(16'h0020);
    step(0, 0, 0, 0, 1, 0, 1, 16'h0100);       // ses_sel=1, flush next cycle
    idle(2);
    branch(16'h0040);
    step(0, 0, 1, 0, 0, 0, 0, 16'h0000);       // exception entry: epc 0x0042
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0, 16'h0000);       // rti back to 0x0042
    idle(1);
    branch(16'hFFFE);
    idle(2);                                   // wraps to 0x0000
    step(0, 0, 1, 0, 0, 0, 0, 16'h0000);
    do_reset();                                // reset while in EXC
    step(0, 0, 1, 0, 0, 0, 0, 16'h0000);
    idle(2);
    step(0, 0, 1, 0, 1, 0, 0, 16'h1234);       // double fault -> HALT
    for (int i = 0; i < 6; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), 16'($urandom));
    do_reset();
    for (int ep = 0; ep < 25; ep++) begin
      for (int i = 0; i < 40; i++) begin
        tgt = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 9) == 0) tgt = 16'hFFFE;
        step($urandom_range(0, 99) < 15, $urandom_range(0, 199) < 3,
             $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 30, $urandom_range(0, 1),
             $urandom_range(0, 1), tgt);
      end
      do_reset();
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
